instr_encoder: RTL and testbench

Packs discrete instruction fields (opcode, register selects, mode bit, 8-bit immediate) into the CPU's 16-bit instruction word; the inverse of the instruction decoder. Used by the program loader and debug front end to build instruction memory contents in hardware. Fields arrive over a valid/ready handshake. Encoded words leave through a 2-entry output FIFO, each tagged with an auto-incrementing instruction-memory address.

---
 rtl/instr_encoder_pkg.sv | 54 +++++
 rtl/instr_encoder_pack.sv | 45 ++++
 rtl/instr_encoder.sv | 118 +++++++++++
 tb/tb_instr_encoder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared opcode set and instruction-word field positions for the encoder and decoder.
// Used by instr_pack and instr_encoder.
package instr_encoder_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_OR     = 4'h2,
    OP_XOR    = 4'h3,
    OP_AND    = 4'h4,
    OP_NOT    = 4'h5,
    OP_READ   = 4'h6,
    OP_WRITE  = 4'h7,
    OP_LOAD   = 4'h8,
    OP_CMP    = 4'h9,
    OP_SHL    = 4'hA,
    OP_SHR    = 4'hB,
    OP_JUMPEQ = 4'hC,
    OP_JMP    = 4'hD,
    OP_SPEC   = 4'hE,
    OP_RSVD   = 4'hF
  } opcode_t;

  // Common fields
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int MODE_BIT   = 8;

  // Register select fields
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 9;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 5;
  localparam int RB_MSB = 4;
  localparam int RB_LSB = 2;

  // Immediate fields; WRITE splits imm[7:2] across the rD and low slots
  localparam int WR_IMM_HI_MSB = 11;
  localparam int WR_IMM_HI_LSB = 9;
  localparam int WR_IMM_LO_MSB = 2;
  localparam int WR_IMM_LO_LSB = 0;
  localparam int IMM8_MSB      = 7;
  localparam int IMM8_LSB      = 0;
  localparam int IMM5_MSB      = 4;
  localparam int IMM5_LSB      = 0;

  // True when an 8-bit immediate survives truncation to a signed 5-bit field.
  function automatic logic imm5_fits(input logic [7:0] imm);
    return imm[7:5] == {3{imm[4]}};
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational field-to-word packing plus a flag that the
// immediate is representable in the selected format.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]         I_opcode,
  input  logic [2:0]         I_rD_select,
  input  logic [2:0]         I_rA_select,
  input  logic [2:0]         I_rB_select,
  input  logic               I_mode,
  input  logic [7:0]         I_immediate,
  output logic [INSTR_W-1:0] O_word,
  output logic               O_representable
);

  always_comb begin
    O_word          = '0;
    O_representable = 1'b1;
    O_word[OPCODE_MSB:OPCODE_LSB] = I_opcode;
    O_word[MODE_BIT]              = I_mode;
    case (I_opcode)
      OP_WRITE: begin
        O_word[WR_IMM_HI_MSB:WR_IMM_HI_LSB] = I_immediate[7:5];
        O_word[RA_MSB:RA_LSB]               = I_rA_select;
        O_word[WR_IMM_LO_MSB:WR_IMM_LO_LSB] = I_immediate[4:2];
        O_representable                     = (I_immediate[1:0] == 2'b00);
      end
      OP_LOAD, OP_JMP: begin
        O_word[RD_MSB:RD_LSB]     = I_rD_select;
        O_word[IMM8_MSB:IMM8_LSB] = I_immediate;
      end
      default: begin
        O_word[RD_MSB:RD_LSB] = I_rD_select;
        O_word[RA_MSB:RA_LSB] = I_rA_select;
        if (I_mode) begin
          O_word[IMM5_MSB:IMM5_LSB] = I_immediate[4:0];
          O_representable           = imm5_fits(I_immediate);
        end else begin
          O_word[RB_MSB:RB_LSB] = I_rB_select;
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field sets, packs them, tags each with an address and
// queues them in a 2-entry FIFO. Optional immediate range check: ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               I_enable,
  input  logic               I_valid,
  output logic               O_ready,
  input  logic [3:0]         I_opcode,
  input  logic [2:0]         I_rD_select,
  input  logic [2:0]         I_rA_select,
  input  logic [2:0]         I_rB_select,
  input  logic               I_mode,
  input  logic [7:0]         I_immediate,
  input  logic               I_addr_load,
  input  logic [ADDR_W-1:0]  I_addr_base,
  output logic               O_valid,
  input  logic               I_ready,
  output logic [INSTR_W-1:0] O_instruction,
  output logic [ADDR_W-1:0]  O_addr,
  output logic               O_error
);

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
  } entry_t;

  entry_t             entry_reg [2];
  entry_t             entry_next [2];
  logic [1:0]         count_reg, count_next;
  logic [ADDR_W-1:0]  addr_cnt_reg, addr_cnt_next;
  logic               error_reg, error_next;

  logic [INSTR_W-1:0] packed_word;
  logic               fits;
  logic               accept, reject, push, pop;
  logic [ADDR_W-1:0]  tag;
  entry_t             new_entry;

  instr_pack u_pack (
    .I_opcode        (I_opcode),
    .I_rD_select     (I_rD_select),
    .I_rA_select     (I_rA_select),
    .I_rB_select     (I_rB_select),
    .I_mode          (I_mode),
    .I_immediate     (I_immediate),
    .O_word          (packed_word),
    .O_representable (fits)
  );

  // Ready depends only on registered occupancy, never on I_ready.
  assign O_ready   = !I_reset && I_enable && (count_reg != 2'd2);
  assign accept    = I_valid && O_ready;
  assign reject    = RANGE_CHECK && !fits;
  assign push      = accept && !reject;
  assign pop       = (count_reg != 2'd0) && I_ready;
  assign tag       = I_addr_load ? I_addr_base : addr_cnt_reg;
  assign new_entry = '{instr: packed_word, addr: tag};

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    entry_next = entry_reg;
    count_next = count_reg;
    case ({push, pop})
      2'b10: begin
        entry_next[count_reg[0]] = new_entry;
        count_next = count_reg + 2'd1;
      end
      2'b01: begin
        entry_next[0] = entry_reg[1];
        count_next = count_reg - 2'd1;
      end
      2'b11: entry_next[0] = new_entry;  // only reachable at count 1
      default: ;
    endcase
  end

  always_comb begin
    addr_cnt_next = addr_cnt_reg;
    if (push)
      addr_cnt_next = tag + ADDR_W'(1);
    else if (I_addr_load)
      addr_cnt_next = I_addr_base;
  end

  assign error_next = accept && reject;

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      count_reg    <= 2'd0;
      addr_cnt_reg <= '0;
      error_reg    <= 1'b0;
      for (int i = 0; i < 2; i++) entry_reg[i] <= '0;
    end else begin
      count_reg    <= count_next;
      addr_cnt_reg <= addr_cnt_next;
      error_reg    <= error_next;
      for (int i = 0; i < 2; i++) entry_reg[i] <= entry_next[i];
    end
  end

  assign O_valid       = (count_reg != 2'd0);
  assign O_instruction = entry_reg[0].instr;
  assign O_addr        = entry_reg[0].addr;
  assign O_error       = error_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: table vectors, hand sequences and random
// traffic against a queue-based reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int ADDR_W = 8;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst, en, valid, rdy, load, mode;
  logic [3:0]  op;
  logic [2:0]  rd, ra, rb;
  logic [7:0]  imm, base;
  logic        O_ready, O_valid, O_error;
  logic [15:0] O_instruction;
  logic [7:0]  O_addr;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .I_clk(clk), .I_reset(rst), .I_enable(en), .I_valid(valid), .O_ready(O_ready),
    .I_opcode(op), .I_rD_select(rd), .I_rA_select(ra), .I_rB_select(rb),
    .I_mode(mode), .I_immediate(imm), .I_addr_load(load), .I_addr_base(base),
    .O_valid(O_valid), .I_ready(rdy), .O_instruction(O_instruction),
    .O_addr(O_addr), .O_error(O_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] word;
    logic [7:0]  addr;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic        mode;
    logic [7:0]  imm;
    logic [15:0] word;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  logic [7:0] m_cnt;
  logic       m_err;
  bit         m_zero_head;
  int         checks, failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the field layout, using plain arithmetic.
  function automatic void model_encode(input int o, input int d, input int a, input int b,
                                       input int m, input int i,
                                       output logic [15:0] w, output bit rep);
    int iw, s;
    iw  = o * 4096 + m * 256;
    rep = 1'b1;
    if (o == int'(OP_WRITE)) begin
      iw += (i / 32) * 512 + a * 32 + (i / 4) % 8;
      rep = (i % 4) == 0;
    end else if (o == int'(OP_LOAD) || o == int'(OP_JMP)) begin
      iw += d * 512 + i;
    end else begin
      iw += d * 512 + a * 32;
      if (m != 0) begin
        iw += i % 32;
        s = (i >= 128) ? i - 256 : i;
        rep = (s >= -16) && (s <= 15);
      end else begin
        iw += b * 4;
      end
    end
    w = iw[15:0];
  endfunction

  task automatic set_fields(input logic [3:0] o, input logic [2:0] d, input logic [2:0] a,
                            input logic [2:0] b, input logic m, input logic [7:0] i);
    op = o; rd = d; ra = a; rb = b; mode = m; imm = i;
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: compare outputs with the model, then advance model across the edge.
  task automatic cycle();
    bit exp_ready, acc, pop, rep, rej;
    logic [15:0] w;
    logic [7:0]  tag;
    #1;
    exp_ready = !rst && en && (exp_q.size() < 2);
    check("ready", O_ready, exp_ready);
    check("valid", O_valid, exp_q.size() != 0);
    check("error", O_error, m_err);
    if (exp_q.size() != 0) begin
      check("instr", O_instruction, exp_q[0].word);
      check("addr", O_addr, exp_q[0].addr);
    end else if (m_zero_head) begin
      check("instr_zero", O_instruction, 0);
      check("addr_zero", O_addr, 0);
    end
    acc = valid && exp_ready;
    pop = (exp_q.size() != 0) && rdy;
    model_encode(int'(op), int'(rd), int'(ra), int'(rb), int'(mode), int'(imm), w, rep);
    rej = acc && RC && !rep;
    tag = load ? base : m_cnt;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_cnt = 8'd0;
      m_err = 1'b0;
      m_zero_head = 1'b1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc && !rej) begin
        exp_q.push_back('{word: w, addr: tag});
        m_cnt = tag + 8'd1;
        m_zero_head = 1'b0;
      end else if (load) begin
        m_cnt = base;
      end
      m_err = rej;
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1; en = 1; valid = 0; rdy = 0; load = 0; base = 0;
    set_fields(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    m_cnt = 0; m_err = 0; m_zero_head = 1;

    tbl.push_back('{OP_WRITE, 3'd0, 3'd3, 3'd0, 1'b0, 8'hA4, {OP_WRITE, 3'b101, 1'b0, 3'b011, 2'b00, 3'b001}});
    tbl.push_back('{OP_LOAD,  3'd2, 3'd0, 3'd0, 1'b1, 8'h7F, {OP_LOAD, 3'b010, 1'b1, 8'h7F}});
    tbl.push_back('{OP_JMP,   3'd0, 3'd0, 3'd0, 1'b0, 8'h00, {OP_JMP, 3'b000, 1'b0, 8'h00}});
    tbl.push_back('{OP_ADD,   3'd1, 3'd4, 3'd0, 1'b1, 8'hF0, {OP_ADD, 3'b001, 1'b1, 3'b100, 5'b10000}});
    tbl.push_back('{OP_SUB,   3'd7, 3'd6, 3'd5, 1'b0, 8'hFF, {OP_SUB, 3'b111, 1'b0, 3'b110, 3'b101, 2'b00}});
    tbl.push_back('{OP_XOR,   3'd3, 3'd2, 3'd1, 1'b1, 8'h0F, {OP_XOR, 3'b011, 1'b1, 3'b010, 5'b01111}});
    tbl.push_back('{OP_WRITE, 3'd5, 3'd7, 3'd2, 1'b1, 8'hFC, {OP_WRITE, 3'b111, 1'b1, 3'b111, 2'b00, 3'b111}});
    tbl.push_back('{OP_LOAD,  3'd7, 3'd5, 3'd3, 1'b0, 8'h80, {OP_LOAD, 3'b111, 1'b0, 8'h80}});
`ifndef ENC_RANGE_CHECK_EN
    tbl.push_back('{OP_ADD,   3'd2, 3'd1, 3'd0, 1'b1, 8'h30, {OP_ADD, 3'b010, 1'b1, 3'b001, 5'b10000}});
    tbl.push_back('{OP_WRITE, 3'd0, 3'd0, 3'd0, 1'b0, 8'hA5, {OP_WRITE, 3'b101, 1'b0, 3'b000, 2'b00, 3'b001}});
`endif

    // Reset state
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 0;

    // Table vectors: one word each, popped the cycle after it appears
    rdy = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      set_fields(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].mode, tbl[i].imm);
      valid = 1;
      cycle();
      valid = 0;
      settle();
      check("tbl_valid", O_valid, 1);
      check("tbl_word", O_instruction, tbl[i].word);
      check("tbl_addr", O_addr, i);
      cycle();
    end

`ifdef ENC_RANGE_CHECK_EN
    // Rejected immediates: error pulse, no word, counter unchanged
    set_fields(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 8'h30);
    valid = 1;
    cycle();
    valid = 0;
    settle();
    check("rc_alu_err", O_error, 1);
    check("rc_alu_noword", O_valid, 0);
    cycle();
    settle();
    check("rc_err_single", O_error, 0);
    set_fields(OP_WRITE, 3'd0, 3'd2, 3'd0, 1'b0, 8'hA5);
    valid = 1;
    cycle();
    valid = 0;
    settle();
    check("rc_wr_err", O_error, 1);
    check("rc_wr_noword", O_valid, 0);
    cycle();
    set_fields(OP_LOAD, 3'd1, 3'd0, 3'd0, 1'b0, 8'h12);
    valid = 1;
    cycle();
    valid = 0;
    settle();
    check("rc_tag_kept", O_addr, tbl.size());
    cycle();
`endif

    // Backpressure: three sets with I_ready low, then release
    rst = 1;
    cycle();
    rst = 0;
    rdy = 0;
    valid = 1;
    set_fields(OP_LOAD, 3'd1, 3'd0, 3'd0, 1'b0, 8'h11);
    cycle();
    set_fields(OP_LOAD, 3'd2, 3'd0, 3'd0, 1'b0, 8'h22);
    cycle();
    set_fields(OP_LOAD, 3'd3, 3'd0, 3'd0, 1'b0, 8'h33);
    settle();
    check("bp_ready_low", O_ready, 0);
    cycle();
    rdy = 1;
    settle();
    check("bp_ready_still_low", O_ready, 0);
    check("bp_tag0", O_addr, 0);
    cycle();
    settle();
    check("bp_tag1", O_addr, 1);
    check("bp_ready_back", O_ready, 1);
    cycle();
    valid = 0;
    settle();
    check("bp_tag2", O_addr, 2);
    check("bp_word2", O_instruction, {OP_LOAD, 3'b011, 1'b0, 8'h33});
    cycle();
    settle();
    check("bp_drained", O_valid, 0);

    // Address wrap and load coincident with accept
    load = 1; base = 8'hFF;
    cycle();
    load = 0;
    valid = 1;
    set_fields(OP_JMP, 3'd0, 3'd0, 3'd0, 1'b0, 8'h01);
    cycle();
    settle();
    check("wrap_ff", O_addr, 8'hFF);
    cycle();
    valid = 0;
    settle();
    check("wrap_00", O_addr, 8'h00);
    cycle();
    load = 1; base = 8'h40; valid = 1;
    cycle();
    load = 0;
    settle();
    check("load_acc_tag", O_addr, 8'h40);
    cycle();
    valid = 0;
    settle();
    check("load_acc_next", O_addr, 8'h41);
    cycle();

    // Reset with two words queued
    rdy = 0; valid = 1;
    cycle();
    cycle();
    valid = 0;
    settle();
    check("rst_queued", O_valid, 1);
    rst = 1;
    cycle();
    settle();
    check("rst_valid", O_valid, 0);
    check("rst_instr", O_instruction, 0);
    check("rst_addr", O_addr, 0);
    check("rst_ready_low", O_ready, 0);
    rst = 0;
    settle();
    check("rst_ready_back", O_ready, 1);
    valid = 1;
    cycle();
    valid = 0;
    settle();
    check("rst_cnt0", O_addr, 0);
    rdy = 1;
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 7) != 0);
      valid = $urandom_range(0, 1) != 0;
      rdy   = ($urandom_range(0, 3) != 0);
      load  = ($urandom_range(0, 15) == 0);
      base  = 8'($urandom);
      set_fields(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                 1'($urandom), 8'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
